// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared definitions for the instruction fetch sequencer:
//                default widths, reset PC and the skid-FIFO entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Default widths. fetch_entry_t is built from these, so the top-level
    // ADDR_W / INSTR_W parameters are expected to keep these values.
    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_INSTR_W    = 72;
    localparam int DEF_FIFO_DEPTH = 2;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;

    // One buffered fetch result: the instruction word and the PC it came from.
    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Sequential PC step; wraps modulo 2^DEF_ADDR_W.
    function automatic logic [DEF_ADDR_W-1:0] pc_next(input logic [DEF_ADDR_W-1:0] pc);
        return pc + 1'b1;
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_fifo
//  Description : Two-entry skid FIFO of fetch_entry_t. Slot 0 is always the
//                head, so the head output is a plain register that keeps its
//                last value once the FIFO drains.
//  Ports       : clk, i_rst        - clock, synchronous active-high reset
//                i_push/i_push_data- write one entry
//                i_pop             - consume the head entry
//                i_flush           - drop all entries (overrides push/pop)
//                o_count           - number of valid entries (0..2)
//                o_head            - head entry
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    localparam logic [1:0] c_FULL = 2'(FIFO_DEPTH);

    fetch_entry_t r_slot0;
    fetch_entry_t r_slot1;
    logic [1:0]   r_count;

    logic w_pop;
    logic w_push;

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only
    // taken when the head leaves in the same cycle.
    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != c_FULL) | w_pop);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_count <= '0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else if (i_flush) begin
            // Slots keep their contents so the head output holds its value.
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b11: begin
                    // Occupancy unchanged: shift the queue forward by one.
                    if (r_count == c_FULL) begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= i_push_data;
                    end else begin
                        r_slot0 <= i_push_data;
                    end
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_slot0 <= i_push_data;
                    end else begin
                        r_slot1 <= i_push_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    // Popping the last entry leaves slot 0 untouched.
                    if (r_count == c_FULL) begin
                        r_slot0 <= r_slot1;
                    end
                    r_count <= r_count - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_slot0;

    a_count_bound: assert property (@(posedge clk) disable iff (i_rst)
        r_count <= c_FULL);

    a_no_overflow: assert property (@(posedge clk) disable iff (i_rst)
        !(i_push && !i_flush && (r_count == c_FULL) && !w_pop));

endmodule : fetch_skid_fifo
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction fetch front end. Owns the PC, addresses the
//                instruction memory (one-cycle read latency), captures the
//                returned word and buffers it in a 2-entry skid FIFO feeding
//                decode over a valid/ready handshake. Supports redirects,
//                decode back-pressure and a fetch-enable gate.
//  Ports       : clk, reset               - clock, sync active-high reset
//                fetch_en                 - allow new memory requests
//                redirect_valid/redirect_pc - taken branch/jump target
//                mem_addr / mem_rdata     - instruction memory interface
//                out_valid/out_ready      - decode handshake
//                out_instr/out_pc         - head instruction and its PC
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                INSTR_W    = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = DEF_RESET_PC,
    parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    localparam logic [2:0] c_SLOTS = 3'(FIFO_DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;

    logic [1:0]   w_count;
    fetch_entry_t w_head;
    fetch_entry_t w_push_entry;
    logic         w_pop;
    logic         w_push;
    logic         w_issue;
    logic [2:0]   w_occupancy;

    // The redirect masks the output, so nothing is consumed in that cycle.
    assign out_valid = (w_count != 2'd0) & ~redirect_valid;
    assign w_pop     = out_valid & out_ready;

    // Words buffered plus the word in flight, after this cycle's pop. A new
    // request is only made if its data is guaranteed a FIFO slot on return;
    // w_pop implies w_count >= 1, so the subtraction never underflows.
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = fetch_en & ~redirect_valid & (w_occupancy < c_SLOTS);

    // A redirect discards the word returning this cycle.
    assign w_push             = r_inflight & ~redirect_valid;
    assign w_push_entry.instr = mem_rdata;
    assign w_push_entry.pc    = r_inflight_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_pc          <= pc_next(r_pc);
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    // Memory samples the address every edge; the result is only kept when
    // the corresponding cycle was an issue (tracked by r_inflight).
    assign mem_addr = r_pc;

    fetch_skid_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_skid_fifo (
        .clk         (clk),
        .i_rst       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;

    a_depth_fixed: assert property (@(posedge clk) FIFO_DEPTH == 2);

    a_no_empty_pop: assert property (@(posedge clk) disable iff (reset)
        w_pop |-> (w_count != 2'd0));

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. A scoreboard queue
//                holds the PC stream decode should see (contiguous from the
//                last reset/redirect target); a monitor pops and compares on
//                every accepted handshake. Directed timing checks plus a
//                randomized phase; a second instance checks PC wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int AW = 10;
    localparam int IW = 72;
    localparam logic [AW-1:0] c_RST_PC_A = 10'd0;
    localparam logic [AW-1:0] c_RST_PC_W = 10'd1022;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, fetch_en, redirect_valid, out_ready;
    logic [AW-1:0] redirect_pc, mem_addr, out_pc;
    logic [IW-1:0] mem_rdata, out_instr;
    logic          out_valid;

    logic          reset_w;
    logic [AW-1:0] mem_addr_w, out_pc_w;
    logic [IW-1:0] mem_rdata_w, out_instr_w;
    logic          out_valid_w;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;
    bit mon_en   = 1'b0;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_w[$];

    fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(c_RST_PC_A), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(c_RST_PC_W), .FIFO_DEPTH(2)) u_dut_wrap (
        .clk(clk), .reset(reset_w), .fetch_en(1'b1),
        .redirect_valid(1'b0), .redirect_pc(10'd0),
        .mem_addr(mem_addr_w), .mem_rdata(mem_rdata_w),
        .out_valid(out_valid_w), .out_ready(1'b1),
        .out_instr(out_instr_w), .out_pc(out_pc_w)
    );

    // Memory contents: low bits equal the address, upper bits scrambled.
    function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
        logic [31:0] x;
        x = 32'(a) * 32'h9E37_79B1;
        return {x, 30'(x >> 3), a};
    endfunction

    always @(posedge clk) begin
        mem_rdata   <= word(mem_addr);
        mem_rdata_w <= word(mem_addr_w);
    end

    task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic refill();
        logic [AW-1:0] t;
        while (exp_q.size() < 64) begin
            t = exp_q[exp_q.size()-1] + 1'b1;
            exp_q.push_back(t);
        end
    endtask

    task automatic start_stream(input logic [AW-1:0] pc);
        exp_q.delete();
        exp_q.push_back(pc);
        refill();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) refill();
    endtask

    // Scoreboard monitor: every accepted word must be the next expected PC.
    always @(negedge clk) begin
        logic [AW-1:0] e;
        if (mon_en && !reset && out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: actual=pc %0h accepted required=no output", out_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", IW'(out_pc), IW'(e));
                chk("sb_instr", out_instr, word(e));
                n_pops++;
            end
        end
    end

    // Wrap instance: decode always ready, first six outputs checked.
    always @(negedge clk) begin
        logic [AW-1:0] e;
        if (mon_en && !reset_w && out_valid_w === 1'b1 && exp_w.size() != 0) begin
            e = exp_w.pop_front();
            chk("wrap_pc", IW'(out_pc_w), IW'(e));
            chk("wrap_instr", out_instr_w, word(e));
        end
    end

    initial begin
        int r;
        reset = 1'b1; reset_w = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; out_ready = 1'b0;
        repeat (3) tick();

        @(negedge clk);
        chk("rst_valid", IW'(out_valid), IW'(0));
        chk("rst_mem_addr", IW'(mem_addr), IW'(c_RST_PC_A));
        chk("rst_out_pc", IW'(out_pc), IW'(0));
        chk("rst_out_instr", out_instr, '0);
        chk("rst_wrap_addr", IW'(mem_addr_w), IW'(c_RST_PC_W));
        start_stream(c_RST_PC_A);
        exp_w = '{10'd1022, 10'd1023, 10'd0, 10'd1, 10'd2, 10'd3};
        mon_en = 1'b1;

        // Streaming start-up: first valid two cycles after release.
        tick(); reset = 1'b0; reset_w = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        @(negedge clk); chk("lat_c0_valid", IW'(out_valid), IW'(0));
        tick(); @(negedge clk); chk("lat_c1_valid", IW'(out_valid), IW'(0));
        tick(); @(negedge clk); chk("lat_c2_valid", IW'(out_valid), IW'(1));
        chk("lat_c2_pc", IW'(out_pc), IW'(0));
        for (int k = 1; k <= 3; k++) begin
            tick(); @(negedge clk);
            chk("stream_valid", IW'(out_valid), IW'(1));
            chk("stream_pc", IW'(out_pc), IW'(k));
        end

        // Back-pressure with head at pc 4.
        tick(); out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", IW'(out_valid), IW'(1));
            chk("bp_pc", IW'(out_pc), IW'(4));
            chk("bp_mem_addr", IW'(mem_addr), IW'(6));
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_resume_valid", IW'(out_valid), IW'(1));
            chk("bp_resume_pc", IW'(out_pc), IW'(4 + i));
            tick();
        end

        // Fill the FIFO, then redirect.
        out_ready = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 10'h200; start_stream(10'h200);
        @(negedge clk); chk("redir_mask", IW'(out_valid), IW'(0));
        tick(); redirect_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); chk("redir_t1_valid", IW'(out_valid), IW'(0));
        chk("redir_t1_addr", IW'(mem_addr), IW'(10'h200));
        tick(); @(negedge clk); chk("redir_t2_valid", IW'(out_valid), IW'(0));
        tick(); @(negedge clk); chk("redir_t3_valid", IW'(out_valid), IW'(1));
        chk("redir_t3_pc", IW'(out_pc), IW'(10'h200));
        tick(); @(negedge clk); chk("redir_t4_pc", IW'(out_pc), IW'(10'h201));

        // fetch_en low for three cycles.
        tick(); fetch_en = 1'b0;
        @(negedge clk); chk("fe_head_pc", IW'(out_pc), IW'(10'h202));
        tick(); @(negedge clk);
        chk("fe_inflight_valid", IW'(out_valid), IW'(1));
        chk("fe_inflight_pc", IW'(out_pc), IW'(10'h203));
        tick(); @(negedge clk); chk("fe_gap", IW'(out_valid), IW'(0));
        tick(); fetch_en = 1'b1;
        @(negedge clk); chk("fe_gap2", IW'(out_valid), IW'(0));
        tick(); @(negedge clk); chk("fe_gap3", IW'(out_valid), IW'(0));
        tick(); @(negedge clk);
        chk("fe_resume_valid", IW'(out_valid), IW'(1));
        chk("fe_resume_pc", IW'(out_pc), IW'(10'h204));

        // Reset while two words are buffered.
        tick(); out_ready = 1'b0;
        tick();
        reset = 1'b1; start_stream(c_RST_PC_A);
        tick(); reset = 1'b0; out_ready = 1'b1;
        @(negedge clk); chk("mrst_valid0", IW'(out_valid), IW'(0));
        tick(); @(negedge clk); chk("mrst_valid1", IW'(out_valid), IW'(0));
        tick(); @(negedge clk);
        chk("mrst_first_valid", IW'(out_valid), IW'(1));
        chk("mrst_first_pc", IW'(out_pc), IW'(c_RST_PC_A));

        // Randomized traffic; the scoreboard checks every accepted word.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            reset = 1'b0; redirect_valid = 1'b0;
            fetch_en  = ($urandom_range(7) != 0);
            out_ready = ($urandom_range(3) != 0);
            r = int'($urandom_range(499));
            if (r == 0) begin
                reset = 1'b1;
                start_stream(c_RST_PC_A);
            end else if (r < 13) begin
                redirect_valid = 1'b1;
                redirect_pc    = AW'($urandom);
                start_stream(redirect_pc);
            end
        end
        tick(); reset = 1'b0; redirect_valid = 1'b0;
        repeat (4) tick();

        n_checks++;
        if (n_pops > 500) n_pass++;
        else $display("FAIL liveness: actual=%0d accepted required=more than 500", n_pops);
        chk("wrap_all_seen", IW'(exp_w.size()), IW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_sequencer
`default_nettype wire
